// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the writeback stage: result-source select,
// load size/sign codes and the FSM state encoding.
package wb_pkg;

   typedef enum logic [1:0] {
      WB_NPC = 2'b00,
      WB_ALU = 2'b01,
      WB_MEM = 2'b10,
      WB_IMM = 2'b11
   } wb_sel_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_MEM = 1'b1
   } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// Bundle between the MEM stage / data memory (master) and the writeback stage (slave).
// Handshake: an instruction transfers on a rising edge where in_valid && in_ready.
interface wb_stage_if #(
   parameter int N     = 32,
   parameter int RA_W  = 5,
   parameter int CNT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic             flush;
   logic [1:0]       wb_sel;
   logic [2:0]       funct3;
   logic             rd_we_in;
   logic [RA_W-1:0]  rd_addr;
   logic [N-1:0]     alu_res;
   logic [N-1:0]     npc;
   logic [N-1:0]     imm;
   logic [N-1:0]     mem_rdata;
   logic             mem_rvalid;
   logic             rf_we;
   logic [RA_W-1:0]  rf_waddr;
   logic [N-1:0]     rf_wdata;
   logic [CNT_W-1:0] retired;
   logic             busy;

   modport master (
      output in_valid, flush, wb_sel, funct3, rd_we_in, rd_addr,
             alu_res, npc, imm, mem_rdata, mem_rvalid,
      input  in_ready, rf_we, rf_waddr, rf_wdata, retired, busy
   );

   modport slave (
      input  in_valid, flush, wb_sel, funct3, rd_we_in, rd_addr,
             alu_res, npc, imm, mem_rdata, mem_rvalid,
      output in_ready, rf_we, rf_waddr, rf_wdata, retired, busy
   );
endinterface

// File: rtl/wb_stage_load_align.sv
// Combinational load extraction: picks the byte/half at the captured offset
// and sign- or zero-extends it; unknown size codes fall back to a full word.
module load_align
   import wb_pkg::*;
(
   input  logic [31:0] i_mem_rdata,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_offset,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_mem_rdata[7:0];
      case (i_offset)
         2'd0: w_byte = i_mem_rdata[7:0];
         2'd1: w_byte = i_mem_rdata[15:8];
         2'd2: w_byte = i_mem_rdata[23:16];
         2'd3: w_byte = i_mem_rdata[31:24];
         default: w_byte = i_mem_rdata[7:0];
      endcase
      w_half = i_offset[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
   end

   always_comb begin
      o_data = i_mem_rdata;
      case (i_funct3)
         F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
         F3_LH:   o_data = {{16{w_half[15]}}, w_half};
         F3_LW:   o_data = i_mem_rdata;
         F3_LBU:  o_data = {24'd0, w_byte};
         F3_LHU:  o_data = {16'd0, w_half};
         default: o_data = i_mem_rdata;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Registered writeback stage: selects the retiring result, waits for load data,
// drives the register-file write port and counts retired instructions.
module wb_stage
   import wb_pkg::*;
#(
   parameter int N     = 32,  // sub-word load alignment assumes 32
   parameter int RA_W  = 5,
   parameter int CNT_W = 32
) (
   input  logic      clk,
   input  logic      rst,
   wb_stage_if.slave bus,
   output wb_state_e o_state
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   wb_state_e        r_state;
   wb_state_e        w_next_state;
   logic             w_in_ready;
   logic             w_busy;
   logic             w_accept;
   logic             w_is_load;
   logic             w_load_done;
   logic [N-1:0]     w_sel_data;
   logic [N-1:0]     w_load_data;

   logic [RA_W-1:0]  r_rd_addr;
   logic             r_rd_we;
   logic [2:0]       r_funct3;
   logic [1:0]       r_offset;

   logic             r_rf_we;
   logic [RA_W-1:0]  r_rf_waddr;
   logic [N-1:0]     r_rf_wdata;
   logic [CNT_W-1:0] r_retired;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:     if (w_accept && w_is_load)          w_next_state = WAIT_MEM;
         WAIT_MEM: if (bus.flush || bus.mem_rvalid)    w_next_state = IDLE;
         default:                                      w_next_state = IDLE;
      endcase
   end

   // Readiness follows the registered state only, so a completing load
   // cannot overlap with a new acceptance.
   always_comb begin
      w_in_ready = 1'b0;
      w_busy     = 1'b0;
      case (r_state)
         IDLE:     w_in_ready = !bus.flush;
         WAIT_MEM: w_busy     = 1'b1;
         default:  w_in_ready = 1'b0;
      endcase
   end

   assign w_accept    = bus.in_valid && w_in_ready;
   assign w_is_load   = (wb_sel_e'(bus.wb_sel) == WB_MEM);
   assign w_load_done = (r_state == WAIT_MEM) && bus.mem_rvalid && !bus.flush;

   always_comb begin
      w_sel_data = bus.alu_res;
      case (wb_sel_e'(bus.wb_sel))
         WB_NPC:  w_sel_data = bus.npc;
         WB_ALU:  w_sel_data = bus.alu_res;
         WB_IMM:  w_sel_data = bus.imm;
         default: w_sel_data = bus.alu_res;
      endcase
   end

   load_align u_load_align (
      .i_mem_rdata (bus.mem_rdata),
      .i_funct3    (r_funct3),
      .i_offset    (r_offset),
      .o_data      (w_load_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_addr <= '0;
         r_rd_we   <= 1'b0;
         r_funct3  <= '0;
         r_offset  <= '0;
      end else if (r_state == IDLE && w_accept && w_is_load) begin
         r_rd_addr <= bus.rd_addr;
         r_rd_we   <= bus.rd_we_in;
         r_funct3  <= bus.funct3;
         r_offset  <= bus.alu_res[1:0];
      end
   end

   // Address and data only move on a real write, so they hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rf_we    <= 1'b0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
         r_retired  <= '0;
      end else begin
         r_rf_we <= 1'b0;
         if (r_state == IDLE && w_accept && !w_is_load) begin
            r_retired <= r_retired + CNT_ONE;
            if (bus.rd_we_in && bus.rd_addr != '0) begin
               r_rf_we    <= 1'b1;
               r_rf_waddr <= bus.rd_addr;
               r_rf_wdata <= w_sel_data;
            end
         end else if (w_load_done) begin
            r_retired <= r_retired + CNT_ONE;
            if (r_rd_we && r_rd_addr != '0) begin
               r_rf_we    <= 1'b1;
               r_rf_waddr <= r_rd_addr;
               r_rf_wdata <= w_load_data;
            end
         end
      end
   end

   assign bus.in_ready = w_in_ready;
   assign bus.busy     = w_busy;
   assign bus.rf_we    = r_rf_we;
   assign bus.rf_waddr = r_rf_waddr;
   assign bus.rf_wdata = r_rf_wdata;
   assign bus.retired  = r_retired;
   assign o_state      = r_state;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vectors followed by random traffic, all checked
// against a transaction-level model of the writeback rules.
module tb_wb_stage;
   import wb_pkg::*;

   localparam int N     = 32;
   localparam int RA_W  = 5;
   localparam int CNT_W = 4;

   logic      clk;
   logic      rst;
   wb_state_e state;

   wb_stage_if #(.N(N), .RA_W(RA_W), .CNT_W(CNT_W)) bus ();

   wb_stage #(.N(N), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus.slave),
      .o_state (state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference model
   typedef struct {
      logic [RA_W-1:0] rd;
      logic            we;
      logic [2:0]      f3;
      logic [1:0]      off;
   } load_t;

   load_t           pend_q[$];
   logic [N-1:0]    exp_q[$];
   logic            exp_we;
   logic [RA_W-1:0] exp_waddr;
   int unsigned     exp_ret;

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] off);
      int unsigned b, h;
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (16 * off[1])) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 128)   ? b + 32'hFFFF_FF00 : b;
         3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   task automatic model_edge();
      load_t p;
      exp_we = 1'b0;
      exp_q.delete();
      if (rst) begin
         pend_q.delete();
         exp_ret = 0;
      end else if (pend_q.size() != 0) begin
         if (bus.flush) pend_q.delete();
         else if (bus.mem_rvalid) begin
            p = pend_q.pop_front();
            exp_ret = (exp_ret + 1) % (1 << CNT_W);
            if (p.we && p.rd != 0) begin
               exp_we = 1'b1;
               exp_waddr = p.rd;
               exp_q.push_back(ref_load(bus.mem_rdata, p.f3, p.off));
            end
         end
      end else if (bus.in_valid && !bus.flush) begin
         if (bus.wb_sel == 2'b10) begin
            p.rd = bus.rd_addr; p.we = bus.rd_we_in; p.f3 = bus.funct3; p.off = bus.alu_res[1:0];
            pend_q.push_back(p);
         end else begin
            exp_ret = (exp_ret + 1) % (1 << CNT_W);
            if (bus.rd_we_in && bus.rd_addr != 0) begin
               exp_we = 1'b1;
               exp_waddr = bus.rd_addr;
               exp_q.push_back(bus.wb_sel == 2'b00 ? bus.npc :
                               bus.wb_sel == 2'b01 ? bus.alu_res : bus.imm);
            end
         end
      end
   endtask

   // driver tasks
   task automatic set_idle();
      rst = 1'b0;
      bus.in_valid = 1'b0; bus.flush = 1'b0; bus.wb_sel = 2'b01; bus.funct3 = 3'b0;
      bus.rd_we_in = 1'b0; bus.rd_addr = '0; bus.alu_res = '0; bus.npc = '0; bus.imm = '0;
      bus.mem_rdata = '0; bus.mem_rvalid = 1'b0;
   endtask

   task automatic tick();
      logic pend;
      #1;
      pend = (pend_q.size() != 0);
      check("in_ready", bus.in_ready, !pend && !bus.flush);
      @(posedge clk);
      model_edge();
      #1;
      check("rf_we", bus.rf_we, exp_we);
      if (exp_we) begin
         check("rf_waddr", bus.rf_waddr, exp_waddr);
         check("rf_wdata", bus.rf_wdata, exp_q[0]);
      end
      check("retired", bus.retired, exp_ret[CNT_W-1:0]);
      check("busy", bus.busy, pend_q.size() != 0);
      check("state", state, (pend_q.size() != 0) ? WAIT_MEM : IDLE);
   endtask

   task automatic drive_op(input logic [1:0] sel, input logic [RA_W-1:0] rd, input logic we,
                           input logic [N-1:0] val);
      bus.in_valid = 1'b1; bus.wb_sel = sel; bus.rd_addr = rd; bus.rd_we_in = we;
      bus.alu_res = val; bus.npc = val ^ 32'h0F0F_0000; bus.imm = val ^ 32'h00FF_00FF;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic do_load(input logic [2:0] f3, input logic [1:0] off, input logic [RA_W-1:0] rd,
                          input logic [N-1:0] word, input int gap);
      bus.in_valid = 1'b1; bus.wb_sel = 2'b10; bus.funct3 = f3; bus.rd_addr = rd;
      bus.rd_we_in = 1'b1; bus.alu_res = {28'h0001_000, 2'b00, off};
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < gap; i++) tick();
      bus.mem_rvalid = 1'b1; bus.mem_rdata = word;
      tick();
      bus.mem_rvalid = 1'b0;
      tick();
   endtask

   initial begin
      set_idle();
      exp_ret = 0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      tick();
      check("reset_rf_waddr", bus.rf_waddr, 0);
      check("reset_rf_wdata", bus.rf_wdata, 0);
      rst = 1'b0;

      drive_op(2'b01, 5, 1'b1, 32'h0000_1234);
      check("alu_wdata", bus.rf_wdata, 32'h0000_1234);
      check("alu_retired", bus.retired, 1);

      bus.in_valid = 1'b1; bus.wb_sel = 2'b10; bus.funct3 = F3_LB; bus.rd_addr = 7;
      bus.rd_we_in = 1'b1; bus.alu_res = 32'h0000_0102;
      tick();
      bus.in_valid = 1'b0;
      tick(); tick();
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1280_3456;
      tick();
      bus.mem_rvalid = 1'b0;
      check("lb_sign", bus.rf_wdata, 32'hFFFF_FF80);
      tick();

      do_load(F3_LHU, 2'b10, 9, 32'h8001_7FFF, 1);
      check("lhu_data", bus.rf_wdata, 32'h0000_8001);
      do_load(F3_LH, 2'b10, 9, 32'h8001_7FFF, 0);
      check("lh_hi", bus.rf_wdata, 32'hFFFF_8001);
      do_load(F3_LH, 2'b00, 10, 32'h8001_7FFF, 2);
      check("lh_lo", bus.rf_wdata, 32'h0000_7FFF);

      bus.in_valid = 1'b1; bus.wb_sel = 2'b11; bus.rd_addr = 0; bus.rd_we_in = 1'b1;
      bus.imm = 32'hDEAD_BEEF;
      tick();
      check("x0_no_write", bus.rf_we, 0);
      bus.rd_addr = 3; bus.rd_we_in = 1'b0;
      tick();
      check("nowe_no_write", bus.rf_we, 0);
      bus.in_valid = 1'b0;

      bus.in_valid = 1'b1; bus.wb_sel = 2'b10; bus.funct3 = F3_LW; bus.rd_addr = 4; bus.rd_we_in = 1'b1;
      tick();
      bus.in_valid = 1'b0; bus.flush = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hAAAA_5555;
      tick();
      check("flush_no_write", bus.rf_we, 0);
      bus.flush = 1'b0; bus.mem_rvalid = 1'b0;
      drive_op(2'b01, 6, 1'b1, 32'h0000_00C3);
      check("after_flush_we", bus.rf_we, 1);

      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 17; i++) drive_op(2'(i % 4 == 2 ? 0 : i % 4), 5'($urandom_range(1, 31)), 1'b1, $urandom);
      check("retired_wrap", bus.retired, 1);

      bus.in_valid = 1'b1; bus.wb_sel = 2'b10; bus.funct3 = F3_LW; bus.rd_addr = 8; bus.rd_we_in = 1'b1;
      tick();
      bus.in_valid = 1'b0; rst = 1'b1;
      tick();
      check("rst_busy", bus.busy, 0);
      check("rst_retired", bus.retired, 0);
      rst = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1357_9BDF;
      tick();
      check("rst_stale_rvalid", bus.rf_we, 0);
      bus.mem_rvalid = 1'b0;

      for (int i = 0; i < 400; i++) begin
         rst            = ($urandom_range(0, 99) < 2);
         bus.in_valid   = ($urandom_range(0, 99) < 70);
         bus.flush      = ($urandom_range(0, 99) < 10);
         bus.wb_sel     = 2'($urandom_range(0, 3));
         bus.funct3     = 3'($urandom_range(0, 7));
         bus.rd_we_in   = ($urandom_range(0, 99) < 85);
         bus.rd_addr    = 5'($urandom_range(0, 31));
         bus.alu_res    = $urandom;
         bus.npc        = $urandom;
         bus.imm        = $urandom;
         bus.mem_rdata  = $urandom;
         bus.mem_rvalid = ($urandom_range(0, 99) < 35);
         tick();
      end
      set_idle();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
# wb_stage

Registered, parametrised writeback stage for the RISC-V lite pipeline. It accepts one retiring instruction per cycle from the MEM stage and selects the result from NPC, ALU, memory or immediate. Loads wait for an asynchronous memory response and get byte/half extraction with sign or zero extension. It drives the register-file write port and keeps a retired-instruction counter.

## Interface
- `N`, 32: datapath width; must be 32 for sub-word load alignment.
- `RA_W`, 5: register index width.
- `CNT_W`, 32: retired-instruction counter width.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  MEM stage presents an instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `flush`  in  1  kill any in-flight load; block acceptance this cycle.
- `wb_sel`  in  2  00 NPC, 01 ALU, 10 MEM, 11 IMM (from CU).
- `funct3`  in  3  load size/sign, used only when `wb_sel`=10.
- `rd_we_in`  in  1  instruction writes rd.
- `rd_addr`  in  RA_W  destination register.
- `alu_res`  in  N  ALU result; bits [1:0] are the load byte offset.
- `npc`  in  N  next PC.
- `imm`  in  N  immediate.
- `mem_rdata`  in  N  aligned 32-bit word from data memory.
- `mem_rvalid`  in  1  `mem_rdata` valid.
- `rf_we`  out  1  register-file write enable.
- `rf_waddr`  out  RA_W  write address.
- `rf_wdata`  out  N  write data.
- `retired`  out  CNT_W  count of completed instructions.
- `busy`  out  1  load outstanding.

## Operation
- FSM states: IDLE, WAIT_MEM.
- IDLE:
  - `in_ready` = !flush.
  - Accept when `in_valid && in_ready`.
  - If `wb_sel` != 10: register the selected source into `rf_wdata`, set `rf_we` = `rd_we_in && rd_addr!=0`, `rf_waddr` = `rd_addr`, and increment `retired`. Stay in IDLE.
  - If `wb_sel` = 10: capture `rd_addr`, `rd_we_in`, `funct3` and `alu_res[1:0]`, then go to WAIT_MEM. No write occurs.
- WAIT_MEM:
  - `in_ready`=0 and `busy`=1.
  - On `mem_rvalid`: register the extracted load data, `rf_we` (same rd≠0 rule) and `rf_waddr`, increment `retired`, and return to IDLE.
  - On `flush` (takes priority over `mem_rvalid`): return to IDLE with no write and no retire.
- `mem_rvalid` is ignored in IDLE.
- Load extraction:
  - 000 LB: byte at offset[1:0], sign-extended.
  - 001 LH: half at offset[1], sign-extended.
  - 010 LW: full word, offset ignored.
  - 100 LBU / 101 LHU: as LB / LH but zero-extended.
  - Other codes: treated as LW.
- `rf_we` is a one-cycle pulse; `rf_wdata` and `rf_waddr` hold their last value when `rf_we`=0.
- `retired` wraps modulo 2^CNT_W. It counts instructions with `rd_we_in`=0 and writes to x0.

## Timing
- Reset values: `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `retired`=0, `busy`=0, state IDLE. `in_ready` is 1 after reset unless `flush`.
- Non-load latency: `rf_we` is asserted in the cycle after acceptance. Throughput is 1 per cycle.
- Load latency: `rf_we` is asserted in the cycle after the `mem_rvalid` sample. The minimum is 2 cycles from acceptance, because `mem_rvalid` can be sampled no earlier than the cycle after acceptance.
- Back-to-back: a new instruction can be accepted in the same cycle that `mem_rvalid` returns the FSM to IDLE? No. `in_ready` follows the state register, so acceptance resumes in the cycle after the load completes.
- Reset in any state: next cycle all outputs are at reset values and any pending load is discarded.

## Structure
- Package `wb_pkg`:
  - `wb_sel_e` enum (WB_NPC=00, WB_ALU=01, WB_MEM=10, WB_IMM=11).
  - Load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - `wb_state_e` enum (IDLE, WAIT_MEM).
- Sub-module `load_align`: combinational; inputs `mem_rdata`, `funct3`, offset; output extended word.
- Top-level contents: FSM, capture registers, output registers, counter.

## Test plan
- ALU writeback: accept `wb_sel`=01, `alu_res`=0x0000_1234, `rd_addr`=5, `rd_we_in`=1 → next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0x0000_1234, `retired`=1.
- LB sign: `wb_sel`=10, `funct3`=000, `alu_res`[1:0]=2'b10, `mem_rvalid` 3 cycles later with `mem_rdata`=0x12_80_34_56 → `rf_wdata`=0xFFFF_FF80. `in_ready`=0 and `busy`=1 until the cycle after `mem_rvalid`.
- LHU/LH: `mem_rdata`=0x8001_7FFF, offset 2'b10 → LHU gives 0x0000_8001, LH gives 0xFFFF_8001. Offset 2'b00 with LH gives 0x0000_7FFF.
- x0 and no-write: `rd_addr`=0, `wb_sel`=11, `imm`=0xDEAD_BEEF → `rf_we`=0, `retired` increments. `rd_we_in`=0 behaves the same.
- Flush mid-load: accept a load, then assert `flush` together with `mem_rvalid` → no `rf_we`, `retired` unchanged, IDLE next cycle. A following ALU op writes normally.
- Reset/wrap: with `CNT_W`=4, retire 17 instructions → `retired`=1. Asserting `rst` during WAIT_MEM clears `busy` and `retired` next cycle, and a later `mem_rvalid` causes no write.
